alu_controller_seq: RTL and testbench

- Next-generation ALU controller for the RV32 pipeline. Decodes ALUOp/Funct3/Funct7 for the full RV32I ALU and branch set plus the optional RV32M set into a registered EX-stage operation code.
- Sequences multi-cycle multiply/divide ops with an occupancy counter and stall/start/done handshake.
- Sits between the ID/EX decode and the EX-stage ALU / mul-div unit.

---
 rtl/alu_controller_seq_if.sv | 27 ++
 rtl/alu_controller_seq.sv | 191 +++++++++++++++++++
 tb/tb_alu_controller_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_controller_seq_if.sv
// ID/EX-to-EX bundle for the ALU controller: decode fields and flush in,
// registered op code and mul/div sequencing handshake out.
interface alu_controller_seq_if #(
  parameter int OP_W = 5
);
  logic            flush_i;
  logic            valid_i;
  logic [1:0]      ALUOp;
  logic [2:0]      Funct3;
  logic [6:0]      Funct7;
  logic [OP_W-1:0] Operation;
  logic            illegal_o;
  logic            md_start;
  logic            md_busy;
  logic            md_done;
  logic            stall_o;

  modport master (
    output flush_i, valid_i, ALUOp, Funct3, Funct7,
    input  Operation, illegal_o, md_start, md_busy, md_done, stall_o
  );

  modport slave (
    input  flush_i, valid_i, ALUOp, Funct3, Funct7,
    output Operation, illegal_o, md_start, md_busy, md_done, stall_o
  );
endinterface

// File: rtl/alu_controller_seq.sv
// RV32I/M ALU controller: decodes ALUOp/Funct3/Funct7 into a registered EX op code
// and sequences multi-cycle mul/div ops with an occupancy counter.
module alu_controller_seq #(
  parameter int OP_W    = 5,
  parameter int EN_M    = 1,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_controller_seq_if.slave  bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  localparam logic [OP_W-1:0] OP_AND  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_BGE  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_BLTU = OP_W'(12);
  localparam logic [OP_W-1:0] OP_BGEU = OP_W'(13);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(15);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(16);

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            ill_q, ill_d;
  logic            start_q, start_d;

  logic [OP_W-1:0] dec_op;
  logic            dec_ill;
  logic            dec_mul;
  logic            dec_div;
  logic            accept;

  // Funct7=0000000 register/immediate ALU map shared by R-type and I-type.
  function automatic logic [OP_W-1:0] std_op(input logic [2:0] f3);
    logic [OP_W-1:0] r;
    case (f3)
      3'b000:  r = OP_ADD;
      3'b001:  r = OP_SLL;
      3'b010:  r = OP_SLT;
      3'b011:  r = OP_SLTU;
      3'b100:  r = OP_XOR;
      3'b101:  r = OP_SRL;
      3'b110:  r = OP_OR;
      default: r = OP_AND;
    endcase
    return r;
  endfunction

  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    dec_mul = 1'b0;
    dec_div = 1'b0;
    case (bus.ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: begin
        case (bus.Funct3)
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          3'b110:  dec_op = OP_BLTU;
          3'b111:  dec_op = OP_BGEU;
          default: dec_ill = 1'b1;
        endcase
      end
      2'b10: begin
        if (bus.Funct7 == F7_BASE) begin
          dec_op = std_op(bus.Funct3);
        end else if (bus.Funct7 == F7_ALT) begin
          case (bus.Funct3)
            3'b000:  dec_op = OP_SUB;
            3'b101:  dec_op = OP_SRA;
            default: dec_ill = 1'b1;
          endcase
        end else if (bus.Funct7 == F7_MD && EN_M != 0) begin
          // MUL..REMU occupy 16..23 in Funct3 order; bit 2 splits mul from div.
          dec_op  = OP_MUL | OP_W'(bus.Funct3);
          dec_mul = ~bus.Funct3[2];
          dec_div = bus.Funct3[2];
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: begin
        case (bus.Funct3)
          3'b000: dec_op = OP_ADD;
          3'b001: begin
            if (bus.Funct7 == F7_BASE) dec_op = OP_SLL;
            else                       dec_ill = 1'b1;
          end
          3'b101: begin
            if (bus.Funct7 == F7_BASE)     dec_op = OP_SRL;
            else if (bus.Funct7 == F7_ALT) dec_op = OP_SRA;
            else                           dec_ill = 1'b1;
          end
          default: dec_op = std_op(bus.Funct3);
        endcase
      end
    endcase
    if (dec_ill) dec_op = OP_ADD;
  end

  // A new op is taken when EX is free or finishing its last mul/div cycle.
  assign accept = !bus.flush_i && ((state_q == S_IDLE) || (cnt_q == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ill_d   = ill_q;
    start_d = 1'b0;
    if (bus.flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      op_d    = OP_ADD;
      ill_d   = 1'b0;
    end else if (accept) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      if (bus.valid_i) begin
        op_d  = dec_op;
        ill_d = dec_ill;
        if (dec_mul) begin
          state_d = S_BUSY;
          cnt_d   = MUL_CNT;
          start_d = 1'b1;
        end else if (dec_div) begin
          state_d = S_BUSY;
          cnt_d   = DIV_CNT;
          start_d = 1'b1;
        end
      end else begin
        op_d  = OP_ADD;
        ill_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      ill_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
      start_q <= start_d;
    end
  end

  assign bus.Operation = op_q;
  assign bus.illegal_o = ill_q;
  assign bus.md_start  = start_q;
  assign bus.md_busy   = (state_q == S_BUSY);
  assign bus.md_done   = (state_q == S_BUSY) && (cnt_q == '0);
  assign bus.stall_o   = (state_q == S_BUSY) && (cnt_q != '0);

endmodule

// File: tb/tb_alu_controller_seq.sv
// Scoreboard bench: three controller builds (default, MUL_LAT=1/DIV_LAT=3, EN_M=0)
// share one stimulus stream; a latency-based reference model predicts every cycle.
module tb_alu_controller_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush, valid;
  logic [1:0] aluop;
  logic [2:0] f3;
  logic [6:0] f7;

  always #5 clk = ~clk;

  alu_controller_seq_if #(.OP_W(5)) ifa ();
  alu_controller_seq_if #(.OP_W(5)) ifb ();
  alu_controller_seq_if #(.OP_W(5)) ifc ();

  alu_controller_seq #(.OP_W(5), .EN_M(1), .MUL_LAT(4), .DIV_LAT(33)) u_a (
    .clk(clk), .reset(rst), .bus(ifa));
  alu_controller_seq #(.OP_W(5), .EN_M(1), .MUL_LAT(1), .DIV_LAT(3)) u_b (
    .clk(clk), .reset(rst), .bus(ifb));
  alu_controller_seq #(.OP_W(5), .EN_M(0), .MUL_LAT(1), .DIV_LAT(1)) u_c (
    .clk(clk), .reset(rst), .bus(ifc));

  assign ifa.flush_i = flush;  assign ifb.flush_i = flush;  assign ifc.flush_i = flush;
  assign ifa.valid_i = valid;  assign ifb.valid_i = valid;  assign ifc.valid_i = valid;
  assign ifa.ALUOp   = aluop;  assign ifb.ALUOp   = aluop;  assign ifc.ALUOp   = aluop;
  assign ifa.Funct3  = f3;     assign ifb.Funct3  = f3;     assign ifc.Funct3  = f3;
  assign ifa.Funct7  = f7;     assign ifb.Funct7  = f7;     assign ifc.Funct7  = f7;

  logic [4:0] a_op[3];
  logic       a_ill[3], a_st[3], a_bz[3], a_dn[3], a_sl[3];
  assign a_op[0] = ifa.Operation; assign a_op[1] = ifb.Operation; assign a_op[2] = ifc.Operation;
  assign a_ill[0] = ifa.illegal_o; assign a_ill[1] = ifb.illegal_o; assign a_ill[2] = ifc.illegal_o;
  assign a_st[0] = ifa.md_start;  assign a_st[1] = ifb.md_start;  assign a_st[2] = ifc.md_start;
  assign a_bz[0] = ifa.md_busy;   assign a_bz[1] = ifb.md_busy;   assign a_bz[2] = ifc.md_busy;
  assign a_dn[0] = ifa.md_done;   assign a_dn[1] = ifb.md_done;   assign a_dn[2] = ifc.md_done;
  assign a_sl[0] = ifa.stall_o;   assign a_sl[1] = ifb.stall_o;   assign a_sl[2] = ifc.stall_o;

  typedef struct packed {
    logic [4:0] op;
    logic       ill, st, bz, dn, sl;
  } e_t;
  typedef e_t [2:0] ev_t;

  ev_t sbq[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;

  int p_en[3]   = '{1, 1, 0};
  int p_mlat[3] = '{4, 1, 1};
  int p_dlat[3] = '{33, 3, 1};
  int std_map[8] = '{2, 5, 14, 15, 4, 6, 3, 0};
  int br_map[8]  = '{8, 9, -1, -1, 10, 11, 12, 13};

  int m_op[3];
  bit m_ill[3], m_st[3];
  int m_left[3];  // busy cycles still to present, including the current one

  task automatic ref_decode(input int i, input logic [1:0] a, input logic [2:0] fn3,
                            input logic [6:0] fn7, output int op, output bit ill, output int lat);
    op = 2; ill = 0; lat = 0;
    case (a)
      2'd0: op = 2;
      2'd1: if (br_map[fn3] < 0) ill = 1; else op = br_map[fn3];
      2'd2: begin
        if (fn7 == 7'h00) op = std_map[fn3];
        else if (fn7 == 7'h20) begin
          if (fn3 == 0) op = 1; else if (fn3 == 5) op = 7; else ill = 1;
        end else if (fn7 == 7'h01 && p_en[i] == 1) begin
          op  = 16 + int'(fn3);
          lat = (op < 20) ? p_mlat[i] : p_dlat[i];
        end else ill = 1;
      end
      default: begin
        if (fn3 == 0) op = 2;
        else if (fn3 == 1) begin if (fn7 == 7'h00) op = 5; else ill = 1; end
        else if (fn3 == 5) begin
          if (fn7 == 7'h00) op = 6; else if (fn7 == 7'h20) op = 7; else ill = 1;
        end else op = std_map[fn3];
      end
    endcase
    if (ill) op = 2;
  endtask

  task automatic model_edge(input bit r, input bit fl, input bit v, input logic [1:0] a,
                            input logic [2:0] fn3, input logic [6:0] fn7);
    ev_t e;
    int op, lat;
    bit ill;
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0;
      if (r || fl) begin
        m_op[i] = 2; m_ill[i] = 0; m_left[i] = 0;
      end else if (m_left[i] > 1) begin
        m_left[i]--;
      end else if (v) begin
        ref_decode(i, a, fn3, fn7, op, ill, lat);
        m_op[i] = op; m_ill[i] = ill; m_left[i] = lat; m_st[i] = (lat > 0);
      end else begin
        m_op[i] = 2; m_ill[i] = 0; m_left[i] = 0;
      end
      e[i].op  = 5'(m_op[i]);
      e[i].ill = m_ill[i];
      e[i].st  = m_st[i];
      e[i].bz  = (m_left[i] > 0);
      e[i].dn  = (m_left[i] == 1);
      e[i].sl  = (m_left[i] > 1);
    end
    sbq.push_back(e);
  endtask

  task automatic chk(input int i, input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL inst%0d %s cycle %0d: got %0d expected %0d", i, nm, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      ev_t e;
      e = sbq.pop_front();
      for (int i = 0; i < 3; i++) begin
        chk(i, "Operation", int'(a_op[i]), int'(e[i].op));
        chk(i, "illegal_o", int'(a_ill[i]), int'(e[i].ill));
        chk(i, "md_start",  int'(a_st[i]), int'(e[i].st));
        chk(i, "md_busy",   int'(a_bz[i]), int'(e[i].bz));
        chk(i, "md_done",   int'(a_dn[i]), int'(e[i].dn));
        chk(i, "stall_o",   int'(a_sl[i]), int'(e[i].sl));
      end
    end
  end

  task automatic step(input bit r, input bit fl, input bit v, input logic [1:0] a,
                      input logic [2:0] fn3, input logic [6:0] fn7);
    rst = r; flush = fl; valid = v; aluop = a; f3 = fn3; f7 = fn7;
    @(posedge clk);
    cyc++;
    model_edge(r, fl, v, a, fn3, fn7);
    #1;
  endtask

  task automatic rand_step(input bit allow_ctl);
    logic [6:0] rf7;
    case ($urandom_range(0, 3))
      0: rf7 = 7'h00;
      1: rf7 = 7'h20;
      2: rf7 = 7'h01;
      default: rf7 = 7'($urandom);
    endcase
    step(allow_ctl && ($urandom_range(0, 199) == 0),
         allow_ctl && ($urandom_range(0, 29) == 0),
         ($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), rf7);
  endtask

  initial begin
    // reset held two cycles, then released with no instruction
    step(1, 0, 0, 2'd0, 3'd0, 7'h00);
    step(1, 0, 0, 2'd0, 3'd0, 7'h00);
    step(0, 0, 0, 2'd0, 3'd0, 7'h00);
    // single-cycle decode cases
    step(0, 0, 1, 2'd2, 3'd0, 7'h20);  // SUB
    step(0, 0, 1, 2'd2, 3'd7, 7'h00);  // AND
    step(0, 0, 1, 2'd1, 3'd5, 7'h00);  // BGE
    step(0, 0, 1, 2'd1, 3'd2, 7'h00);  // illegal branch
    step(0, 0, 1, 2'd0, 3'd6, 7'h7f);  // load/store ADD
    step(0, 0, 1, 2'd3, 3'd0, 7'h55);  // ADDI, Funct7 ignored
    step(0, 0, 1, 2'd3, 3'd5, 7'h20);  // SRAI
    step(0, 0, 1, 2'd3, 3'd1, 7'h20);  // illegal SLLI
    step(0, 0, 1, 2'd2, 3'd3, 7'h01);  // MULHU (EN_M=0 build: illegal)
    step(0, 0, 0, 2'd0, 3'd0, 7'h00);
    // DIV with inputs churning during stall, ADD presented in the done cycle
    step(0, 0, 1, 2'd2, 3'd4, 7'h01);
    for (int k = 1; k <= 32; k++) rand_step(0);
    step(0, 0, 1, 2'd0, 3'd0, 7'h00);
    step(0, 0, 0, 2'd0, 3'd0, 7'h00);
    // back-to-back MUL then MULHU
    step(0, 0, 1, 2'd2, 3'd0, 7'h01);
    step(0, 0, 1, 2'd2, 3'd3, 7'h01);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 2'd0, 3'd0, 7'h00);
    // DIVU aborted by flush, then by reset, at cycle 5
    for (int pass = 0; pass < 2; pass++) begin
      step(0, 0, 1, 2'd2, 3'd5, 7'h01);
      for (int k = 1; k <= 4; k++) rand_step(0);
      step(pass == 1, pass == 0, 1, 2'd2, 3'd4, 7'h01);
      for (int k = 0; k < 40; k++) step(0, 0, 0, 2'd0, 3'd0, 7'h00);
    end
    // randomized traffic
    for (int k = 0; k < 3000; k++) rand_step(1);
    step(0, 0, 0, 2'd0, 3'd0, 7'h00);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
